// File: rtl/alu_wb_if.sv
// Bundle between the ALU sequencer, the write-back stage and the register/flag files.
// master = sequencer/file side, slave = alu_wb_stage.
interface alu_wb_if #(
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          in_done;
   logic [31:0]   in_data;
   logic [3:0]    in_write_en;
   logic [3:0]    in_Z;
   logic [3:0]    in_N;
   logic [3:0]    in_C;
   logic [3:0]    in_V;
   logic          in_illegal;
   logic [4:0]    in_warp_id;
   logic          wb_ready;

   logic          rf_valid;
   logic          rf_ready;
   logic [31:0]   rf_data;
   logic [3:0]    rf_we;
   logic [4:0]    rf_warp_id;

   logic          flag_valid;
   logic [3:0]    flag_Z;
   logic [3:0]    flag_N;
   logic [3:0]    flag_C;
   logic [3:0]    flag_V;
   logic [4:0]    flag_warp_id;

   logic          illegal_err;
   logic [4:0]    illegal_warp_id;
   logic          overflow_err;
   logic [CW-1:0] fifo_count;
   logic [15:0]   retired_cnt;

   modport master (
      output in_done, in_data, in_write_en, in_Z, in_N, in_C, in_V, in_illegal, in_warp_id,
      output rf_ready,
      input  wb_ready, rf_valid, rf_data, rf_we, rf_warp_id,
      input  flag_valid, flag_Z, flag_N, flag_C, flag_V, flag_warp_id,
      input  illegal_err, illegal_warp_id, overflow_err, fifo_count, retired_cnt
   );

   modport slave (
      input  in_done, in_data, in_write_en, in_Z, in_N, in_C, in_V, in_illegal, in_warp_id,
      input  rf_ready,
      output wb_ready, rf_valid, rf_data, rf_we, rf_warp_id,
      output flag_valid, flag_Z, flag_N, flag_C, flag_V, flag_warp_id,
      output illegal_err, illegal_warp_id, overflow_err, fifo_count, retired_cnt
   );
endinterface

// File: rtl/alu_wb_stage.sv
// ALU write-back stage: buffers finished results in a small FIFO and retires them
// one at a time into the register file and flag file, reporting illegal ops.
module alu_wb_stage #(
   parameter int DEPTH = 4
) (
   input  logic      clk,
   input  logic      rst,
   alu_wb_if.slave   bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  we;
      logic [3:0]  z;
      logic [3:0]  n;
      logic [3:0]  c;
      logic [3:0]  v;
      logic        ill;
      logic [4:0]  warp;
   } entry_t;

   typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_ERR} state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   entry_t        r_mem [DEPTH];
   entry_t        w_in_entry;
   entry_t        w_head;
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_full;
   logic          w_push;
   logic          w_drop;
   logic          w_pop;
   logic          w_retire;
   logic          w_retire_head;

   logic [31:0]   r_out_data;
   logic [3:0]    r_out_we;
   logic [4:0]    r_out_warp;
   logic [3:0]    r_out_z, r_out_n, r_out_c, r_out_v;
   logic          r_flag_valid;
   logic [3:0]    r_flag_z, r_flag_n, r_flag_c, r_flag_v;
   logic [4:0]    r_flag_warp;
   logic          r_ovf;
   logic [15:0]   r_retired;

   assign w_in_entry = '{data: bus.in_data, we: bus.in_write_en, z: bus.in_Z, n: bus.in_N,
                         c: bus.in_C, v: bus.in_V, ill: bus.in_illegal, warp: bus.in_warp_id};
   assign w_head     = r_mem[r_rd_ptr];
   assign w_full     = (r_count == CW'(DEPTH));
   assign w_push     = bus.in_done && !w_full;
   assign w_drop     = bus.in_done && w_full;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Zero-mask entries retire straight from the head without an RF handshake.
   always_comb begin
      w_state_nxt   = r_state;
      w_pop         = 1'b0;
      w_retire      = 1'b0;
      w_retire_head = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_count != '0) begin
               w_pop = 1'b1;
               if (w_head.ill) begin
                  w_state_nxt = S_ERR;
               end else if (w_head.we == 4'h0) begin
                  w_retire      = 1'b1;
                  w_retire_head = 1'b1;
               end else begin
                  w_state_nxt = S_DRIVE;
               end
            end
         end
         S_DRIVE: begin
            if (bus.rf_ready) begin
               w_retire    = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         S_ERR:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_in_entry;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_ovf        <= 1'b0;
         r_out_data   <= '0;
         r_out_we     <= '0;
         r_out_warp   <= '0;
         r_out_z      <= '0;
         r_out_n      <= '0;
         r_out_c      <= '0;
         r_out_v      <= '0;
         r_flag_valid <= 1'b0;
         r_flag_z     <= '0;
         r_flag_n     <= '0;
         r_flag_c     <= '0;
         r_flag_v     <= '0;
         r_flag_warp  <= '0;
         r_retired    <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: ;
         endcase
         if (w_drop) r_ovf <= 1'b1;
         if (w_pop) begin
            r_out_data <= w_head.data;
            r_out_we   <= w_head.we;
            r_out_warp <= w_head.warp;
            r_out_z    <= w_head.z;
            r_out_n    <= w_head.n;
            r_out_c    <= w_head.c;
            r_out_v    <= w_head.v;
         end
         r_flag_valid <= w_retire;
         if (w_retire) begin
            r_flag_z    <= w_retire_head ? w_head.z    : r_out_z;
            r_flag_n    <= w_retire_head ? w_head.n    : r_out_n;
            r_flag_c    <= w_retire_head ? w_head.c    : r_out_c;
            r_flag_v    <= w_retire_head ? w_head.v    : r_out_v;
            r_flag_warp <= w_retire_head ? w_head.warp : r_out_warp;
            r_retired   <= r_retired + 16'd1;
         end
      end
   end

   // One slot stays free so a result already in flight from the sequencer is never lost.
   assign bus.wb_ready        = (r_count < CW'(DEPTH - 1));
   assign bus.rf_valid        = (r_state == S_DRIVE);
   assign bus.rf_data         = r_out_data;
   assign bus.rf_we           = r_out_we;
   assign bus.rf_warp_id      = r_out_warp;
   assign bus.flag_valid      = r_flag_valid;
   assign bus.flag_Z          = r_flag_z;
   assign bus.flag_N          = r_flag_n;
   assign bus.flag_C          = r_flag_c;
   assign bus.flag_V          = r_flag_v;
   assign bus.flag_warp_id    = r_flag_warp;
   assign bus.illegal_err     = (r_state == S_ERR);
   assign bus.illegal_warp_id = r_out_warp;
   assign bus.overflow_err    = r_ovf;
   assign bus.fifo_count      = r_count;
   assign bus.retired_cnt     = r_retired;
endmodule

// File: tb/tb_alu_wb_stage.sv
// Self-checking bench for alu_wb_stage; expected RF writes go through a scoreboard queue.
module tb_alu_wb_stage;
   localparam int DEPTH = 4;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  we;
      logic [4:0]  warp;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   alu_wb_if #(.DEPTH(DEPTH)) bus ();
   alu_wb_stage #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.in_done     = 1'b0;
      bus.in_data     = '0;
      bus.in_write_en = '0;
      bus.in_Z        = '0;
      bus.in_N        = '0;
      bus.in_C        = '0;
      bus.in_V        = '0;
      bus.in_illegal  = 1'b0;
      bus.in_warp_id  = '0;
   endtask

   task automatic set_op(input logic [31:0] d, input logic [3:0] we, input logic [3:0] z,
                         input logic [3:0] n, input logic [3:0] c, input logic [3:0] v,
                         input logic ill, input logic [4:0] w);
      bus.in_done     = 1'b1;
      bus.in_data     = d;
      bus.in_write_en = we;
      bus.in_Z        = z;
      bus.in_N        = n;
      bus.in_C        = c;
      bus.in_V        = v;
      bus.in_illegal  = ill;
      bus.in_warp_id  = w;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b0;
      #4;
      rst = 1'b1;
      sb.delete();
      tick();
   endtask

   task automatic test_reset();
      idle_inputs();
      bus.rf_ready = 1'b1;
      rst = 1'b1;
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if ({bus.rf_valid, bus.rf_data, bus.rf_we, bus.rf_warp_id} !== 42'h0) begin
         errors++;
         $display("FAIL reset_rf: got %h expected 0", {bus.rf_valid, bus.rf_data, bus.rf_we, bus.rf_warp_id});
      end
      checks++;
      if ({bus.flag_valid, bus.flag_Z, bus.flag_N, bus.flag_C, bus.flag_V, bus.flag_warp_id} !== 22'h0) begin
         errors++;
         $display("FAIL reset_flags: got %h expected 0",
                  {bus.flag_valid, bus.flag_Z, bus.flag_N, bus.flag_C, bus.flag_V, bus.flag_warp_id});
      end
      checks++;
      if ({bus.illegal_err, bus.illegal_warp_id, bus.overflow_err, bus.retired_cnt} !== 23'h0) begin
         errors++;
         $display("FAIL reset_status: got %h expected 0",
                  {bus.illegal_err, bus.illegal_warp_id, bus.overflow_err, bus.retired_cnt});
      end
      checks++;
      if (bus.wb_ready !== 1'b1 || bus.fifo_count !== 3'd0) begin
         errors++;
         $display("FAIL reset_fifo: wb_ready=%b count=%0d expected 1/0", bus.wb_ready, bus.fifo_count);
      end
      #5;
      rst = 1'b1;
      tick();
   endtask

   task automatic test_single();
      exp_t e;
      bus.rf_ready = 1'b1;
      set_op(32'h0000_00A5, 4'hF, 4'h1, 4'h2, 4'h4, 4'h8, 1'b0, 5'd3);
      sb.push_back('{32'h0000_00A5, 4'hF, 5'd3});
      tick();
      idle_inputs();
      checks++;
      if (bus.rf_valid !== 1'b0 || bus.fifo_count !== 3'd1) begin
         errors++;
         $display("FAIL single_capture: rf_valid=%b count=%0d expected 0/1", bus.rf_valid, bus.fifo_count);
      end
      tick();
      checks++;
      if (bus.rf_valid !== 1'b1) begin
         errors++;
         $display("FAIL single_latency: rf_valid=%b expected 1", bus.rf_valid);
      end
      e = sb.pop_front();
      checks++;
      if (bus.rf_data !== e.data || bus.rf_we !== e.we || bus.rf_warp_id !== e.warp) begin
         errors++;
         $display("FAIL single_payload: got %h/%h/%0d expected %h/%h/%0d",
                  bus.rf_data, bus.rf_we, bus.rf_warp_id, e.data, e.we, e.warp);
      end
      tick();
      checks++;
      if ({bus.flag_valid, bus.flag_Z, bus.flag_N, bus.flag_C, bus.flag_V, bus.flag_warp_id} !==
          {1'b1, 4'h1, 4'h2, 4'h4, 4'h8, 5'd3}) begin
         errors++;
         $display("FAIL single_flags: got %h expected %h",
                  {bus.flag_valid, bus.flag_Z, bus.flag_N, bus.flag_C, bus.flag_V, bus.flag_warp_id},
                  {1'b1, 4'h1, 4'h2, 4'h4, 4'h8, 5'd3});
      end
      checks++;
      if (bus.retired_cnt !== 16'd1 || bus.rf_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_retire: retired=%0d rf_valid=%b expected 1/0", bus.retired_cnt, bus.rf_valid);
      end
      tick();
      checks++;
      if (bus.flag_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_flag_pulse: flag_valid=%b expected 0", bus.flag_valid);
      end
   endtask

   task automatic test_backpressure();
      exp_t e;
      int   budget;
      do_reset();
      bus.rf_ready = 1'b0;
      set_op(32'h1111_0001, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 5'd1);
      sb.push_back('{32'h1111_0001, 4'h3, 5'd1});
      tick();
      idle_inputs();
      tick();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (bus.rf_valid !== 1'b1 || bus.rf_data !== 32'h1111_0001 || bus.rf_we !== 4'h3 || bus.rf_warp_id !== 5'd1) begin
            errors++;
            $display("FAIL bp_hold: cycle %0d valid=%b data=%h we=%h warp=%0d expected 1/11110001/3/1",
                     i, bus.rf_valid, bus.rf_data, bus.rf_we, bus.rf_warp_id);
         end
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         set_op(32'h2222_0000 + 32'(i), 4'(i + 1), 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 5'(10 + i));
         sb.push_back('{32'h2222_0000 + 32'(i), 4'(i + 1), 5'(10 + i)});
         tick();
      end
      idle_inputs();
      checks++;
      if (bus.wb_ready !== 1'b0 || bus.fifo_count !== 3'd3) begin
         errors++;
         $display("FAIL bp_wb_ready: wb_ready=%b count=%0d expected 0/3", bus.wb_ready, bus.fifo_count);
      end
      set_op(32'h3333_0004, 4'hC, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 5'd20);
      sb.push_back('{32'h3333_0004, 4'hC, 5'd20});
      tick();
      checks++;
      if (bus.fifo_count !== 3'd4 || bus.overflow_err !== 1'b0) begin
         errors++;
         $display("FAIL bp_fill: count=%0d ovf=%b expected 4/0", bus.fifo_count, bus.overflow_err);
      end
      set_op(32'hBAD0_0005, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 5'd21);
      tick();
      idle_inputs();
      checks++;
      if (bus.fifo_count !== 3'd4 || bus.overflow_err !== 1'b1) begin
         errors++;
         $display("FAIL bp_overflow: count=%0d ovf=%b expected 4/1", bus.fifo_count, bus.overflow_err);
      end
      bus.rf_ready = 1'b1;
      budget = 0;
      while (sb.size() > 0 && budget < 40) begin
         if (bus.rf_valid === 1'b1) begin
            e = sb.pop_front();
            checks++;
            if (bus.rf_data !== e.data || bus.rf_we !== e.we || bus.rf_warp_id !== e.warp) begin
               errors++;
               $display("FAIL bp_drain: got %h/%h/%0d expected %h/%h/%0d",
                        bus.rf_data, bus.rf_we, bus.rf_warp_id, e.data, e.we, e.warp);
            end
         end
         tick();
         budget++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL bp_drain_timeout: %0d entries outstanding expected 0", sb.size());
      end
      tick();
      checks++;
      if (bus.overflow_err !== 1'b1 || bus.fifo_count !== 3'd0 || bus.retired_cnt !== 16'd5) begin
         errors++;
         $display("FAIL bp_sticky: ovf=%b count=%0d retired=%0d expected 1/0/5",
                  bus.overflow_err, bus.fifo_count, bus.retired_cnt);
      end
   endtask

   task automatic test_illegal();
      do_reset();
      bus.rf_ready = 1'b1;
      set_op(32'h0000_DEAD, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 1'b1, 5'd7);
      tick();
      idle_inputs();
      tick();
      checks++;
      if (bus.illegal_err !== 1'b1 || bus.illegal_warp_id !== 5'd7) begin
         errors++;
         $display("FAIL illegal_pulse: err=%b warp=%0d expected 1/7", bus.illegal_err, bus.illegal_warp_id);
      end
      checks++;
      if (bus.rf_valid !== 1'b0 || bus.flag_valid !== 1'b0) begin
         errors++;
         $display("FAIL illegal_side: rf_valid=%b flag_valid=%b expected 0/0", bus.rf_valid, bus.flag_valid);
      end
      tick();
      checks++;
      if (bus.illegal_err !== 1'b0 || bus.rf_valid !== 1'b0 || bus.flag_valid !== 1'b0 || bus.retired_cnt !== 16'd0) begin
         errors++;
         $display("FAIL illegal_after: err=%b rf_valid=%b flag_valid=%b retired=%0d expected 0/0/0/0",
                  bus.illegal_err, bus.rf_valid, bus.flag_valid, bus.retired_cnt);
      end
   endtask

   task automatic test_zero_mask();
      set_op(32'h0000_5A5A, 4'h0, 4'h5, 4'h0, 4'hA, 4'h0, 1'b0, 5'd9);
      tick();
      idle_inputs();
      checks++;
      if (bus.flag_valid !== 1'b0 || bus.fifo_count !== 3'd1) begin
         errors++;
         $display("FAIL zm_capture: flag_valid=%b count=%0d expected 0/1", bus.flag_valid, bus.fifo_count);
      end
      tick();
      checks++;
      if ({bus.flag_valid, bus.flag_Z, bus.flag_C, bus.flag_warp_id} !== {1'b1, 4'h5, 4'hA, 5'd9}) begin
         errors++;
         $display("FAIL zm_flags: got %h expected %h",
                  {bus.flag_valid, bus.flag_Z, bus.flag_C, bus.flag_warp_id}, {1'b1, 4'h5, 4'hA, 5'd9});
      end
      checks++;
      if (bus.rf_valid !== 1'b0 || bus.retired_cnt !== 16'd1 || bus.fifo_count !== 3'd0) begin
         errors++;
         $display("FAIL zm_retire: rf_valid=%b retired=%0d count=%0d expected 0/1/0",
                  bus.rf_valid, bus.retired_cnt, bus.fifo_count);
      end
      tick();
      checks++;
      if (bus.flag_valid !== 1'b0 || bus.rf_valid !== 1'b0) begin
         errors++;
         $display("FAIL zm_after: flag_valid=%b rf_valid=%b expected 0/0", bus.flag_valid, bus.rf_valid);
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int   sent = 0;
      int   got = 0;
      int   first = -1;
      int   last = -1;
      int   cyc = 0;
      do_reset();
      bus.rf_ready = 1'b1;
      while ((sent < 10 || sb.size() > 0) && cyc < 100) begin
         if (bus.rf_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL b2b_unexpected: rf_data=%h with empty scoreboard", bus.rf_data);
            end else begin
               e = sb.pop_front();
               if (bus.rf_data !== e.data || bus.rf_we !== e.we || bus.rf_warp_id !== e.warp) begin
                  errors++;
                  $display("FAIL b2b_order: got %h/%h/%0d expected %h/%h/%0d",
                           bus.rf_data, bus.rf_we, bus.rf_warp_id, e.data, e.we, e.warp);
               end
            end
            if (first < 0) first = cyc;
            last = cyc;
            got++;
         end
         if (sent < 10 && bus.wb_ready === 1'b1) begin
            set_op(32'hC0DE_0000 + 32'(sent), 4'(sent % 15 + 1), 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 5'(sent));
            sb.push_back('{32'hC0DE_0000 + 32'(sent), 4'(sent % 15 + 1), 5'(sent)});
            sent++;
         end else begin
            idle_inputs();
         end
         tick();
         cyc++;
      end
      idle_inputs();
      checks++;
      if (got != 10 || sb.size() != 0) begin
         errors++;
         $display("FAIL b2b_count: got %0d writes, %0d outstanding, expected 10/0", got, sb.size());
      end
      checks++;
      if (last - first != 18) begin
         errors++;
         $display("FAIL b2b_rate: span %0d cycles expected 18", last - first);
      end
      checks++;
      if (bus.fifo_count !== 3'd0 || bus.retired_cnt !== 16'd10) begin
         errors++;
         $display("FAIL b2b_final: count=%0d retired=%0d expected 0/10", bus.fifo_count, bus.retired_cnt);
      end
   endtask

   task automatic test_reset_mid_drive();
      int stale = 0;
      do_reset();
      bus.rf_ready = 1'b0;
      set_op(32'h7777_0001, 4'h5, 4'h1, 4'h1, 4'h1, 4'h1, 1'b0, 5'd4);
      tick();
      set_op(32'h7777_0002, 4'h6, 4'h1, 4'h1, 4'h1, 4'h1, 1'b0, 5'd5);
      tick();
      idle_inputs();
      checks++;
      if (bus.rf_valid !== 1'b1 || bus.fifo_count !== 3'd1) begin
         errors++;
         $display("FAIL mid_setup: rf_valid=%b count=%0d expected 1/1", bus.rf_valid, bus.fifo_count);
      end
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if ({bus.rf_valid, bus.rf_data, bus.rf_we, bus.rf_warp_id} !== 42'h0 || bus.fifo_count !== 3'd0 ||
          bus.wb_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_async_clear: rf=%h count=%0d wb_ready=%b expected 0/0/1",
                  {bus.rf_valid, bus.rf_data, bus.rf_we, bus.rf_warp_id}, bus.fifo_count, bus.wb_ready);
      end
      #2;
      rst = 1'b1;
      bus.rf_ready = 1'b1;
      sb.delete();
      for (int i = 0; i < 6; i++) begin
         tick();
         if (bus.rf_valid !== 1'b0 || bus.flag_valid !== 1'b0) stale++;
      end
      checks++;
      if (stale != 0 || bus.fifo_count !== 3'd0 || bus.retired_cnt !== 16'd0) begin
         errors++;
         $display("FAIL mid_no_stale: %0d stale cycles count=%0d retired=%0d expected 0/0/0",
                  stale, bus.fifo_count, bus.retired_cnt);
      end
   endtask

   task automatic test_retired_wrap();
      do_reset();
      bus.rf_ready = 1'b1;
      set_op(32'h0, 4'h0, 4'h3, 4'h0, 4'h0, 4'h0, 1'b0, 5'd2);
      repeat (65535) tick();
      idle_inputs();
      tick();
      checks++;
      if (bus.retired_cnt !== 16'hFFFF || bus.fifo_count !== 3'd0) begin
         errors++;
         $display("FAIL wrap_max: retired=%h count=%0d expected ffff/0", bus.retired_cnt, bus.fifo_count);
      end
      set_op(32'h0, 4'h0, 4'h3, 4'h0, 4'h0, 4'h0, 1'b0, 5'd2);
      tick();
      idle_inputs();
      tick();
      checks++;
      if (bus.retired_cnt !== 16'h0000 || bus.flag_valid !== 1'b1) begin
         errors++;
         $display("FAIL wrap_zero: retired=%h flag_valid=%b expected 0000/1", bus.retired_cnt, bus.flag_valid);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_illegal();
      test_zero_mask();
      test_back_to_back();
      test_reset_mid_drive();
      test_retired_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_wb_stage.md
ALU_WB_STAGE -- requirements
Module: alu_wb_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 4, result FIFO entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset. One clock; reset is asynchronous and active-low.
REQ-004 SHALL have port in_done  input  1  one-cycle result pulse from the ALU sequencer.
REQ-005 SHALL have ports in_data  input  32 and in_write_en  input  4  result value and lane write mask.
REQ-006 SHALL have ports in_Z/in_N/in_C/in_V  input  4 each  per-lane flags.
REQ-007 SHALL have ports in_illegal  input  1 and in_warp_id  input  5  illegal-opcode flag and warp tag.
REQ-008 SHALL have port wb_ready  output  1  space available; feeds the sequencer's wb_ready.
REQ-009 SHALL have ports rf_valid  output  1, rf_ready  input  1, rf_data  output  32, rf_we  output  4, rf_warp_id  output  5  register-file write port.
REQ-010 SHALL have ports flag_valid  output  1, flag_Z/flag_N/flag_C/flag_V  output  4 each, flag_warp_id  output  5  flag-file update.
REQ-011 SHALL have ports illegal_err  output  1, illegal_warp_id  output  5  illegal-op report.
REQ-012 SHALL have ports overflow_err  output  1 (sticky), fifo_count  output  log2(DEPTH)+1, retired_cnt  output  16.

Function
REQ-013 SHALL capture {data, write_en, Z, N, C, V, illegal, warp_id} into the FIFO tail on any cycle in_done=1 and count<DEPTH (count sampled before same-cycle pop).
REQ-014 SHALL drop in_done when count==DEPTH, leave FIFO unchanged, set overflow_err=1 until reset.
REQ-015 SHALL drive wb_ready = (count < DEPTH-1), registered-free combinational from count; one slot always reserved for an in-flight result.
REQ-016 SHALL support push and pop in the same cycle; count then unchanged.
REQ-017 SHALL use FIFO pointers that wrap modulo DEPTH.
REQ-018 SHALL implement FSM states S_IDLE, S_DRIVE, S_ERR.
REQ-019 S_IDLE: if count>0, pop head into output registers; head.illegal=1 -> S_ERR; head.write_en==0 -> retire immediately, stay S_IDLE; else -> S_DRIVE.
REQ-020 S_DRIVE: rf_valid=1 with rf_data/rf_we/rf_warp_id stable; on rf_valid&&rf_ready retire and -> S_IDLE.
REQ-021 S_ERR: illegal_err=1 and illegal_warp_id=head warp for exactly one cycle, no RF write, no flag update, -> S_IDLE.
REQ-022 Retire SHALL pulse flag_valid for one cycle with flag_* and flag_warp_id from the entry, and increment retired_cnt (wraps 0xFFFF->0); illegal entries do not retire.
REQ-023 Latency: in_done at edge E0 into empty FIFO in S_IDLE -> rf_valid high after edge E2 (2 cycles).
REQ-024 rf_valid SHALL NOT drop or change payload while rf_ready=0.
REQ-025 Back-to-back entries SHALL sustain one retire every 2 cycles (S_IDLE pop, S_DRIVE handshake).
REQ-026 rf_we SHALL equal entry write_en exactly; block does not reinterpret lanes.

Reset
REQ-027 rst=0 SHALL asynchronously clear: FIFO pointers, count=0, state=S_IDLE, rf_valid=0, rf_data=0, rf_we=0, rf_warp_id=0, flag_valid=0, flag_*=0, flag_warp_id=0, illegal_err=0, illegal_warp_id=0, overflow_err=0, retired_cnt=0; wb_ready=1 while count=0.
REQ-028 Reset mid-S_DRIVE SHALL discard the pending write with no rf_valid after release; FIFO contents lost.

Verification
REQ-029 Single op: in_done, data=0x0000_00A5, write_en=0xF, warp=3, rf_ready=1 -> rf_valid 2 cycles later with rf_data=0xA5, rf_we=0xF, rf_warp_id=3; flag_valid pulse; retired_cnt=1.
REQ-030 Backpressure: rf_ready=0 for 5 cycles -> rf_valid held, payload constant; fill to 3 entries -> wb_ready=0; 5th push at full -> overflow_err=1, count stays 4.
REQ-031 Illegal: in_illegal=1, warp=7 -> illegal_err 1-cycle pulse with illegal_warp_id=7, no rf_valid, no flag_valid, retired_cnt unchanged.
REQ-032 Zero mask: write_en=0x0, Z=0x5 -> no rf_valid, flag_valid pulse with flag_Z=0x5.
REQ-033 Wrap/simultaneous: 10 ops with push on pop cycles -> in-order rf_data, pointers wrap, count correct; retired_cnt preset path 0xFFFF+1 -> 0.
REQ-034 Async reset asserted mid-S_DRIVE -> all outputs to REQ-027 values immediately, no stale rf_valid after release.
